// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with row synchronizer, press/release
// debounce and a one-cycle key_valid strobe carrying a row-major key code.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
// Row r is sensed on bit ROWS-1-r, column c is driven on bit COLS-1-c.
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_CYCLES     = 100,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic                          clk,
    input  logic                          nRst,
    input  logic [ROWS-1:0]               row,
    output logic [COLS-1:0]               col,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    output logic                          key_held
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int KW = $clog2(ROWS*COLS);
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // One-hot column drive pattern for column index c (column c on bit COLS-1-c)
    function automatic logic [COLS-1:0] col_onehot(input logic [CW-1:0] c);
        logic [COLS-1:0] v;
        v = '0;
        for (int i = 0; i < COLS; i++) begin
            v[COLS-1-i] = (CW'(i) == c);
        end
        return v;
    endfunction

    state_t             r_state;
    logic [COLS-1:0]    r_col;
    logic [CW-1:0]      r_cidx;
    logic [SW-1:0]      r_scnt;
    logic [DW-1:0]      r_dcnt;
    logic [RW-1:0]      r_lrow;
    logic [CW-1:0]      r_lcol;
    logic [KW-1:0]      r_code;
    logic               r_valid;
    logic               r_held;

    // Row synchronizer; the driven column index travels alongside so a
    // synchronized row sample is credited to the column that produced it.
    logic [ROWS-1:0]    r_row_m;
    logic [ROWS-1:0]    r_row_s;
    logic [CW-1:0]      r_cidx_m;
    logic [CW-1:0]      r_cidx_s;

    logic               w_rs_any;
    logic [RW-1:0]      w_first_row;
    logic               w_hit;
    logic [CW-1:0]      w_cidx_next;
    logic [KW-1:0]      w_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    logic [HW-1:0]      r_hcnt;
    logic               r_rep_armed;
    logic               w_rep_fire;
`endif

    // Two-flop synchronizer for row sense plus matching column-index delay line
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_row_m  <= '0;
            r_row_s  <= '0;
            r_cidx_m <= '0;
            r_cidx_s <= '0;
        end else begin
            r_row_m  <= row;
            r_row_s  <= r_row_m;
            r_cidx_m <= r_cidx;
            r_cidx_s <= r_cidx_m;
        end
    end

    // Row decode: lowest pressed row index (MSB-first) and latched-row hit
    always_comb begin
        w_first_row = '0;
        w_hit       = 1'b0;
        for (int i = ROWS-1; i >= 0; i--) begin
            w_first_row = r_row_s[ROWS-1-i] ? RW'(i) : w_first_row;
        end
        for (int i = 0; i < ROWS; i++) begin
            w_hit = (RW'(i) == r_lrow) ? r_row_s[ROWS-1-i] : w_hit;
        end
    end

    assign w_rs_any    = |r_row_s;
    assign w_cidx_next = (r_cidx == CW'(COLS-1)) ? '0 : r_cidx + CW'(1);
    assign w_code      = KW'(r_lrow) * KW'(COLS) + KW'(r_lcol);

`ifdef KEYPAD_REPEAT_EN
    assign w_rep_fire = r_rep_armed ? (r_hcnt == HW'(REPEAT_PERIOD-1))
                                    : (r_hcnt == HW'(REPEAT_DELAY-1));
`endif

    // Scan / debounce / hold FSM with registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= ST_SCAN;
            r_col       <= col_onehot(CW'(0));
            r_cidx      <= '0;
            r_scnt      <= '0;
            r_dcnt      <= '0;
            r_lrow      <= '0;
            r_lcol      <= '0;
            r_code      <= '0;
            r_valid     <= 1'b0;
            r_held      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_hcnt      <= '0;
            r_rep_armed <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (w_rs_any) begin
                        // Re-drive the column the sample came from and freeze it
                        r_lrow  <= w_first_row;
                        r_lcol  <= r_cidx_s;
                        r_cidx  <= r_cidx_s;
                        r_col   <= col_onehot(r_cidx_s);
                        r_scnt  <= '0;
                        r_dcnt  <= '0;
                        r_state <= ST_DEBOUNCE;
                    end else if (r_scnt == SW'(SCAN_CYCLES-1)) begin
                        r_scnt <= '0;
                        r_cidx <= w_cidx_next;
                        r_col  <= col_onehot(w_cidx_next);
                    end else begin
                        r_scnt <= r_scnt + SW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_hit) begin
                        // Bounce: resume scanning from the latched column
                        r_scnt  <= '0;
                        r_dcnt  <= '0;
                        r_state <= ST_SCAN;
                    end else if (r_dcnt == DW'(DEBOUNCE_CYCLES-1)) begin
                        r_valid <= 1'b1;
                        r_code  <= w_code;
                        r_held  <= 1'b1;
                        r_dcnt  <= '0;
                        r_state <= ST_PRESSED;
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!w_hit) begin
                        r_dcnt      <= '0;
                        r_state     <= ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        r_hcnt      <= '0;
                        r_rep_armed <= 1'b0;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (w_rep_fire) begin
                            r_valid     <= 1'b1;
                            r_hcnt      <= '0;
                            r_rep_armed <= 1'b1;
                        end else begin
                            r_hcnt <= r_hcnt + HW'(1);
                        end
`else
                        r_dcnt <= '0;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (w_hit) begin
                        // Release bounce: back to holding, no new strobe
                        r_dcnt  <= '0;
                        r_state <= ST_PRESSED;
                    end else if (r_dcnt == DW'(DEBOUNCE_CYCLES-1)) begin
                        r_held  <= 1'b0;
                        r_dcnt  <= '0;
                        r_scnt  <= '0;
                        r_state <= ST_SCAN;
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_dcnt  <= '0;
                    r_scnt  <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign col       = r_col;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner (ROWS=4, COLS=4, SCAN_CYCLES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_keypad_scanner;

    logic       clk;
    logic       nRst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_vec = 0;
    int n_bad = 0;
    int cnt;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_CYCLES(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .nRst(nRst), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] want, input string tag);
        int k;
        k = 0;
        while (col !== want && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {28'd0, col}, {28'd0, want});
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (key_valid) c++;
        end
    endtask

    initial begin
        nRst = 1'b0;
        row  = 4'b0000;
        @(negedge clk);
        chk("rst_col",   {28'd0, col},      32'h8);
        chk("rst_code",  {28'd0, key_code}, 32'h0);
        chk("rst_valid", {31'd0, key_valid}, 32'h0);
        chk("rst_held",  {31'd0, key_held},  32'h0);
        nRst = 1'b1;

        // Column stepping every 2 cycles
        tick(1); chk("scan_c0", {28'd0, col}, 32'h8);
        tick(1); chk("scan_c1", {28'd0, col}, 32'h4);
        tick(2); chk("scan_c2", {28'd0, col}, 32'h2);

        // 1: asynchronous reset mid-scan takes effect before the next edge
        #2 nRst = 1'b0;
        #1;
        chk("t1_col",   {28'd0, col},       32'h8);
        chk("t1_code",  {28'd0, key_code},  32'h0);
        chk("t1_valid", {31'd0, key_valid}, 32'h0);
        chk("t1_held",  {31'd0, key_held},  32'h0);
        @(negedge clk);
        nRst = 1'b1;

        // 2: R0 at C1 held 20 cycles -> one strobe, code 1, at +7
        wait_col(4'b0100, "t2_wait_c1");
        row = 4'b1000;
        tick(6); chk("t2_valid_early", {31'd0, key_valid}, 32'h0);
        tick(1);
        chk("t2_valid",  {31'd0, key_valid}, 32'h1);
        chk("t2_code",   {28'd0, key_code},  32'h1);
        chk("t2_held",   {31'd0, key_held},  32'h1);
        chk("t2_frozen", {28'd0, col},       32'h4);
        tick(1); chk("t2_single", {31'd0, key_valid}, 32'h0);
        count_valid(12, cnt);
        chk("t2_no_extra", cnt, 32'd0);
        row = 4'b0000;
        tick(6); chk("t2_held_rel", {31'd0, key_held}, 32'h1);
        tick(1); chk("t2_held_fall", {31'd0, key_held}, 32'h0);
        chk("t2_code_keep", {28'd0, key_code}, 32'h1);

        // 3: 3-cycle bounce of R3 at C0 -> no strobe, scanning resumes
        wait_col(4'b1000, "t3_wait_c0");
        row = 4'b0001;
        tick(3);
        row = 4'b0000;
        count_valid(7, cnt);
        chk("t3_no_strobe", cnt, 32'd0);
        chk("t3_col_step", {28'd0, col}, 32'h2);
        chk("t3_held", {31'd0, key_held}, 32'h0);

        // 4: R3 C0 press, release bounce -> no second strobe, held stays
        wait_col(4'b1000, "t4_wait_c0");
        row = 4'b0001;
        tick(7);
        chk("t4_valid", {31'd0, key_valid}, 32'h1);
        chk("t4_code",  {28'd0, key_code},  32'hC);
        tick(5);
        row = 4'b0000;
        tick(2);
        row = 4'b0001;
        count_valid(10, cnt);
        chk("t4_no_restrobe", cnt, 32'd0);
        chk("t4_held_stays", {31'd0, key_held}, 32'h1);
        row = 4'b0000;
        tick(7);
        chk("t4_held_fall", {31'd0, key_held}, 32'h0);

        // 5: R1+R2 at C2 -> R1 wins (code 6); R2 ignored while held
        wait_col(4'b0010, "t5_wait_c2");
        row = 4'b0110;
        tick(7);
        chk("t5_valid", {31'd0, key_valid}, 32'h1);
        chk("t5_code",  {28'd0, key_code},  32'h6);
        count_valid(10, cnt);
        chk("t5_no_extra", cnt, 32'd0);
        row = 4'b0000;
        tick(7);
        chk("t5_held_fall", {31'd0, key_held}, 32'h0);

        // 6: reset during DEBOUNCE aborts the press
        row = 4'b1000;
        tick(4);
        #2 nRst = 1'b0;
        row = 4'b0000;
        #1;
        chk("t6_valid", {31'd0, key_valid}, 32'h0);
        chk("t6_code",  {28'd0, key_code},  32'h0);
        chk("t6_col",   {28'd0, col},       32'h8);
        @(negedge clk);
        nRst = 1'b1;
        count_valid(10, cnt);
        chk("t6_no_strobe", cnt, 32'd0);

        // 40-cycle hold of R0 C0: auto-repeat strobes when enabled
        wait_col(4'b1000, "rep_wait_c0");
        row = 4'b1000;
        count_valid(40, cnt);
        row = 4'b0000;
        begin
            int c2;
            count_valid(20, c2);
            cnt = cnt + c2;
        end
`ifdef KEYPAD_REPEAT_EN
        chk("rep_strobes", cnt, 32'd7);
`else
        chk("rep_strobes", cnt, 32'd1);
`endif
        chk("rep_code", {28'd0, key_code}, 32'h0);
        chk("rep_held_end", {31'd0, key_held}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
